// File: rtl/medidor_pkg.sv
// Shared definitions for the period meter: FSM state encoding and the in-range compare.
package medidor_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    MEDIR = 1'b1
  } estado_t;

  // Callers zero-extend their operands to this width before comparing.
  localparam int CMP_W = 32;

  // The difference is taken one bit wider than the operands so that neither
  // ordering of medida/esperado can underflow.
  function automatic logic en_rango_calc(input logic [CMP_W-1:0] medida,
                                         input logic [CMP_W-1:0] esperado,
                                         input logic [CMP_W-1:0] tol);
    logic [CMP_W:0] diff;
    if (medida >= esperado) diff = {1'b0, medida} - {1'b0, esperado};
    else                    diff = {1'b0, esperado} - {1'b0, medida};
    return (diff <= {1'b0, tol});
  endfunction

endpackage

// File: rtl/sincronizador_flanco.sv
// Front end of the period meter: 2-FF synchronizer, optional stability filter
// (enabled by macro MEDIDOR_FILTRO_GLITCH_EN) and a registered rising-edge pulse.
module sincronizador_flanco
  import medidor_pkg::*;
#(
  parameter int FILTRO_N = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic senal_in,
  output logic flanco
);

  if (FILTRO_N < 1) begin : g_cfg_err
    $error("sincronizador_flanco: FILTRO_N must be at least 1");
  end

  logic sync_p0;
  logic sync_p1;
  logic nivel;
  logic nivel_d;

  // Stage boundary: asynchronous input into the clk domain.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= senal_in;
      sync_p1 <= sync_p0;
    end
  end

`ifdef MEDIDOR_FILTRO_GLITCH_EN
  localparam int FW = $clog2(FILTRO_N + 1);

  logic [FW-1:0] estable;
  logic          nivel_q;

  // Stage boundary: the filtered level follows sync_p1 only after it has
  // disagreed with the current level for FILTRO_N consecutive cycles.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      nivel_q <= 1'b0;
      estable <= '0;
    end else if (sync_p1 == nivel_q) begin
      estable <= '0;
    end else if (estable == FW'(FILTRO_N - 1)) begin
      nivel_q <= sync_p1;
      estable <= '0;
    end else begin
      estable <= estable + FW'(1);
    end
  end

  assign nivel = nivel_q;
`else
  assign nivel = sync_p1;
`endif

  // Stage boundary: registered rising-edge detect.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      nivel_d <= 1'b0;
      flanco  <= 1'b0;
    end else begin
      nivel_d <= nivel;
      flanco  <= nivel & ~nivel_d;
    end
  end

endmodule

// File: rtl/medidor_periodo.sv
// Period meter for a slow square wave sampled in the clk domain; flags range and loss of signal.
// Optional glitch filter in the front end is enabled by macro MEDIDOR_FILTRO_GLITCH_EN.
module medidor_periodo
  import medidor_pkg::*;
#(
  parameter int CNT_W    = 26,
  parameter int ESPERADO = 50_000_000,
  parameter int TOL      = 500_000,
  parameter int TIMEOUT  = 60_000_000,
  parameter int FILTRO_N = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             senal_in,
  output logic [CNT_W-1:0] periodo,
  output logic             periodo_valido,
  output logic             en_rango,
  output logic             senal_presente,
  output logic             perdida
);

  // The counter stops at TIMEOUT, so it can only avoid wrapping if TIMEOUT fits.
  if (CNT_W > CMP_W || longint'(TIMEOUT) >= (longint'(1) << CNT_W)) begin : g_cfg_err
    $error("medidor_periodo: TIMEOUT must be < 2**CNT_W and CNT_W <= 32");
  end

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] UNO       = CNT_W'(1);

  estado_t          estado, estado_d;
  logic [CNT_W-1:0] cuenta, cuenta_d;
  logic [CNT_W-1:0] periodo_d;
  logic             valido_d, rango_d, presente_d, perdida_d;
  logic             flanco;

  sincronizador_flanco #(
    .FILTRO_N (FILTRO_N)
  ) u_sinc (
    .clk      (clk),
    .reset_n  (reset_n),
    .senal_in (senal_in),
    .flanco   (flanco)
  );

  always_comb begin
    estado_d   = estado;
    cuenta_d   = cuenta;
    periodo_d  = periodo;
    valido_d   = 1'b0;
    rango_d    = en_rango;
    presente_d = senal_presente;
    perdida_d  = 1'b0;
    case (estado)
      IDLE: begin
        // First edge only arms the measurement.
        if (flanco) begin
          cuenta_d = UNO;
          estado_d = MEDIR;
        end
      end
      MEDIR: begin
        // An edge on the timeout cycle is still a valid measurement.
        if (flanco) begin
          periodo_d  = cuenta;
          valido_d   = 1'b1;
          rango_d    = en_rango_calc(CMP_W'(cuenta), CMP_W'(ESPERADO), CMP_W'(TOL));
          presente_d = 1'b1;
          cuenta_d   = UNO;
        end else if (cuenta == TIMEOUT_C) begin
          perdida_d  = 1'b1;
          presente_d = 1'b0;
          rango_d    = 1'b0;
          cuenta_d   = '0;
          estado_d   = IDLE;
        end else begin
          cuenta_d   = cuenta + UNO;
        end
      end
      default: estado_d = IDLE;
    endcase
  end

  // Stage boundary: FSM state, counter and output registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      estado         <= IDLE;
      cuenta         <= '0;
      periodo        <= '0;
      periodo_valido <= 1'b0;
      en_rango       <= 1'b0;
      senal_presente <= 1'b0;
      perdida        <= 1'b0;
    end else begin
      estado         <= estado_d;
      cuenta         <= cuenta_d;
      periodo        <= periodo_d;
      periodo_valido <= valido_d;
      en_rango       <= rango_d;
      senal_presente <= presente_d;
      perdida        <= perdida_d;
    end
  end

endmodule
